// File: rtl/time_display.sv
// Binary-to-BCD converter for the run timer readout: a 26-step double-dabble
// engine plus seven-segment decode with optional leading-zero blanking.
module time_display #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [25:0] i_time,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_bcd,
    output logic [55:0] o_seven
);

    // Handshake: a request is taken only when the engine is idle (o_busy=0)
    // and i_valid=1 at a clock edge; i_time is captured on that same edge.
    // Exactly 26 edges later o_done pulses for one cycle with the result.
    // Requests seen while busy are dropped, never queued.

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state;
    logic [25:0] shift_q;
    logic [31:0] bcd_q;
    logic [4:0]  step_q;

    logic [31:0] bcd_adj;
    logic [31:0] bcd_next;
    logic [25:0] shift_next;
    logic [55:0] seven_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        bcd_adj = 32'h0;
        for (int k = 0; k < 8; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            else
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4];
        end
        bcd_next   = {bcd_adj[30:0], shift_q[25]};
        shift_next = {shift_q[24:0], 1'b0};
    end

    // Decode the about-to-be-registered digits; zero_run tracks whether every
    // digit from 7 down to the current one is zero.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        seven_next = 56'h0;
        for (int k = 7; k >= 0; k--) begin
            zero_run = zero_run && (bcd_next[4*k +: 4] == 4'd0);
            if (BLANK_LEADING && (k >= 1) && zero_run)
                seven_next[7*k +: 7] = 7'h7F;
            else
                seven_next[7*k +: 7] = seg7(bcd_next[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= 26'h0;
            bcd_q   <= 32'h0;
            step_q  <= 5'd0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_bcd   <= 32'h0;
            o_seven <= {56{1'b1}};
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shift_q <= i_time;
                        bcd_q   <= 32'h0;
                        step_q  <= 5'd0;
                        o_busy  <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_next;
                    bcd_q   <= bcd_next;
                    step_q  <= step_q + 5'd1;
                    if (step_q == 5'd25) begin
                        o_bcd   <= bcd_next;
                        o_seven <= seven_next;
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
